// File: rtl/dtpu_infifo_feeder_if.sv
// rtl/dtpu_infifo_feeder_if.sv - stream-in / infifo-out signal bundle for dtpu_infifo_feeder
// slave = the feeder itself; master = the DMA/core side that drives it.

interface dtpu_infifo_feeder_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] infifo_dout;
    logic                  infifo_last;
    logic                  infifo_is_empty;
    logic                  infifo_read;

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        output s_axis_tready,
        output infifo_dout,
        output infifo_last,
        output infifo_is_empty,
        input  infifo_read
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        input  s_axis_tready,
        input  infifo_dout,
        input  infifo_last,
        input  infifo_is_empty,
        output infifo_read
    );
endinterface

// File: rtl/dtpu_infifo_feeder.sv
// rtl/dtpu_infifo_feeder.sv - AXI-Stream to dtpu_core infifo FWFT circular buffer
// Optional statistics counters enabled by defining INFIFO_STATS_EN.

module dtpu_infifo_feeder #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    dtpu_infifo_feeder_if.slave   bus,
    output logic [DEPTH_LOG2:0]   fill_level
`ifdef INFIFO_STATS_EN
    ,
    output logic [31:0]           word_count,
    output logic                  underflow_sticky,
    output logic [15:0]           batch_count
`endif
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  tready_q;
    logic                  is_empty;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH:0]   head;

    assign is_empty = (count == '0);

    // flush wins over both ports, so neither side may move a pointer that cycle
    assign wr_fire = bus.s_axis_tvalid & tready_q & ~flush;
    assign rd_fire = bus.infifo_read & ~is_empty & ~flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({wr_fire, rd_fire})
                2'b10:   count_next = count + COUNT_ONE;
                2'b01:   count_next = count - COUNT_ONE;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tready_q <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
            end
            count    <= count_next;
            tready_q <= (count_next != FULL_COUNT);
        end
    end

    // storage is deliberately left out of reset; the empty gating hides stale words
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= {bus.s_axis_tlast, bus.s_axis_tdata};
    end

    assign head = mem[rd_ptr];

    assign bus.s_axis_tready   = tready_q;
    assign bus.infifo_is_empty = is_empty;
    assign bus.infifo_dout     = is_empty ? '0 : head[DATA_WIDTH-1:0];
    assign bus.infifo_last     = is_empty ? 1'b0 : head[DATA_WIDTH];
    assign fill_level          = count;

`ifdef INFIFO_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count       <= '0;
            underflow_sticky <= 1'b0;
            batch_count      <= '0;
        end else if (flush) begin
            word_count       <= '0;
            underflow_sticky <= 1'b0;
            batch_count      <= '0;
        end else begin
            if (wr_fire) word_count <= word_count + 32'd1;
            if (bus.infifo_read & is_empty) underflow_sticky <= 1'b1;
            if (rd_fire & head[DATA_WIDTH]) batch_count <= batch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dtpu_infifo_feeder.sv
// tb/tb_dtpu_infifo_feeder.sv - queue-model bench for dtpu_infifo_feeder
// Set INFIFO_STATS_EN to also cover the statistics ports.

module tb_dtpu_infifo_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  fill_level;
`ifdef INFIFO_STATS_EN
    logic [31:0] word_count;
    logic        underflow_sticky;
    logic [15:0] batch_count;
`endif

    dtpu_infifo_feeder_if #(.DATA_WIDTH(64)) bus ();

    dtpu_infifo_feeder #(.DATA_WIDTH(64), .DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .bus        (bus),
        .fill_level (fill_level)
`ifdef INFIFO_STATS_EN
        ,
        .word_count       (word_count),
        .underflow_sticky (underflow_sticky),
        .batch_count      (batch_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    logic [64:0] m_q[$];
    bit          m_tready = 1'b0;
    logic [31:0] m_wc = '0;
    bit          m_us = 1'b0;
    logic [15:0] m_bc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_tready = 1'b0;
        m_wc = '0;
        m_us = 1'b0;
        m_bc = '0;
    endtask

    // what one rising edge must do, given the inputs that were held across it
    task automatic model_step();
        bit wr, rd;
        if (reset) begin
            model_reset();
        end else if (flush) begin
            m_q.delete();
            m_tready = 1'b1;
            m_wc = '0;
            m_us = 1'b0;
            m_bc = '0;
        end else begin
            wr = bus.s_axis_tvalid && m_tready;
            rd = bus.infifo_read && (m_q.size() != 0);
            if (bus.infifo_read && m_q.size() == 0) m_us = 1'b1;
            if (rd) begin
                if (m_q[0][64]) m_bc++;
                void'(m_q.pop_front());
            end
            if (wr) begin
                m_q.push_back({bus.s_axis_tlast, bus.s_axis_tdata});
                m_wc++;
            end
            m_tready = (m_q.size() != 16);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("is_empty", 64'(bus.infifo_is_empty), 64'(m_q.size() == 0));
            chk("dout", bus.infifo_dout, (m_q.size() != 0) ? m_q[0][63:0] : 64'd0);
            chk("last", 64'(bus.infifo_last), (m_q.size() != 0) ? 64'(m_q[0][64]) : 64'd0);
            chk("fill_level", 64'(fill_level), 64'(m_q.size()));
            chk("tready", 64'(bus.s_axis_tready), 64'(m_tready));
`ifdef INFIFO_STATS_EN
            chk("word_count", 64'(word_count), 64'(m_wc));
            chk("underflow_sticky", 64'(underflow_sticky), 64'(m_us));
            chk("batch_count", 64'(batch_count), 64'(m_bc));
`endif
        end
    end

    task automatic cyc(input bit v, input logic [63:0] d, input bit l, input bit rd, input bit fl);
        bus.s_axis_tvalid = v;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = l;
        bus.infifo_read   = rd;
        flush             = fl;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.infifo_read   = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        cmp_en = 1'b1;

        // reset state and tready release
        repeat (2) idle();
        chk("rst_empty", 64'(bus.infifo_is_empty), 64'd1);
        chk("rst_dout", bus.infifo_dout, 64'd0);
        chk("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        reset = 1'b0;
        chk("rel_tready_before_edge", 64'(bus.s_axis_tready), 64'd0);
        idle();
        chk("rel_tready_after_edge", 64'(bus.s_axis_tready), 64'd1);

        // two words, second carries tlast
        cyc(1'b1, 64'hCAFECAFECAFECAFE, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h3501350135013501, 1'b1, 1'b0, 1'b0);
        bus.s_axis_tvalid = 1'b0;
        chk("two_fill", 64'(fill_level), 64'd2);
        chk("two_dout", bus.infifo_dout, 64'hCAFECAFECAFECAFE);
        cyc(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        chk("two_dout_after_read", bus.infifo_dout, 64'h3501350135013501);
        chk("two_last_after_read", 64'(bus.infifo_last), 64'd1);
        cyc(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

        // fill to 16, offer a 17th, then drain in order
        for (int i = 0; i < 16; i++) cyc(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
        chk("full_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("full_fill", 64'(fill_level), 64'd16);
        cyc(1'b1, 64'd16, 1'b0, 1'b0, 1'b0);
        chk("full_17th_rejected", 64'(fill_level), 64'd16);
        chk("full_head", bus.infifo_dout, 64'd0);
        cyc(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        chk("full_read_tready", 64'(bus.s_axis_tready), 64'd1);
        chk("full_read_fill", 64'(fill_level), 64'd15);
        for (int i = 1; i < 16; i++) begin
            chk("drain_order", bus.infifo_dout, 64'(i));
            cyc(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_empty", 64'(bus.infifo_is_empty), 64'd1);

        // steady state at 3 words across pointer wrap
        for (int i = 0; i < 3; i++) cyc(1'b1, 64'(100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 64'(103 + i), 1'b0, 1'b1, 1'b0);
            chk("steady_fill", 64'(fill_level), 64'd3);
            chk("steady_head", bus.infifo_dout, 64'(101 + i));
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

        // read while empty, then write+read on empty
        cyc(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        chk("uf_fill", 64'(fill_level), 64'd0);
        chk("uf_empty", 64'(bus.infifo_is_empty), 64'd1);
`ifdef INFIFO_STATS_EN
        chk("uf_sticky", 64'(underflow_sticky), 64'd1);
`endif
        cyc(1'b1, 64'h5555AAAA5555AAAA, 1'b0, 1'b1, 1'b0);
        chk("wr_rd_empty_fill", 64'(fill_level), 64'd1);
        chk("wr_rd_empty_dout", bus.infifo_dout, 64'h5555AAAA5555AAAA);

        // flush with 5 stored plus an in-flight word
        for (int i = 0; i < 4; i++) cyc(1'b1, 64'(200 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_flush_fill", 64'(fill_level), 64'd5);
        cyc(1'b1, 64'hDEAD, 1'b1, 1'b0, 1'b1);
        chk("flush_fill", 64'(fill_level), 64'd0);
        chk("flush_empty", 64'(bus.infifo_is_empty), 64'd1);
        chk("flush_tready", 64'(bus.s_axis_tready), 64'd1);
        idle();
        chk("flush_discard", 64'(bus.infifo_is_empty), 64'd1);

        // randomized traffic with writer-heavy and reader-heavy phases
        for (int i = 0; i < 2000; i++) begin
            bit heavy_wr;
            heavy_wr = ((i / 100) % 2) == 0;
            cyc(($urandom_range(0, 99) < (heavy_wr ? 85 : 35)),
                {$urandom, $urandom},
                1'($urandom_range(0, 3) == 0),
                ($urandom_range(0, 99) < (heavy_wr ? 35 : 85)),
                ($urandom_range(0, 199) == 0));
        end

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 6; i++) cyc(1'b1, 64'(300 + i), 1'b1, 1'b0, 1'b0);
        bus.s_axis_tvalid = 1'b1;
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("async_empty", 64'(bus.infifo_is_empty), 64'd1);
        chk("async_fill", 64'(fill_level), 64'd0);
        chk("async_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("async_dout", bus.infifo_dout, 64'd0);
        chk("async_last", 64'(bus.infifo_last), 64'd0);
        @(posedge clk);
        model_step();
        #1 reset = 1'b0;
        idle();
        chk("post_reset_tready", 64'(bus.s_axis_tready), 64'd1);
        repeat (2) idle();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dtpu_infifo_feeder.md
Name: dtpu_infifo_feeder

Overview:
- Producer end of the dtpu_core input-data FIFO interface (infifo_is_empty / infifo_dout / infifo_read).
- Accepts AXI-Stream words from the DMA side into a circular buffer.
- Presents them to the core first-word-fall-through (FWFT).
- Sits between the PS DMA stream and dtpu_core; replaces the bench-driven infifo stimulus.

Parameters:
- DATA_WIDTH, 64, stream and infifo word width (matches DATA_WIDTH_FIFO_IN).
- DEPTH_LOG2, 4, log2 of buffer depth; DEPTH = 2**DEPTH_LOG2 = 16 words.

Ports:
- clk  in  1  single clock; everything samples on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of buffer contents.
- s_axis_tdata  in  DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream word valid.
- s_axis_tlast  in  1  last word of a tensor batch.
- s_axis_tready  out  1  buffer can accept a word.
- infifo_dout  out  DATA_WIDTH  head word, FWFT.
- infifo_last  out  1  tlast stored with head word.
- infifo_is_empty  out  1  no word available.
- infifo_read  in  1  core pops head word this cycle.
- fill_level  out  DEPTH_LOG2+1  words currently stored (0..DEPTH).

Behaviour:
- Storage: DEPTH entries of DATA_WIDTH+1 bits (data plus tlast). Write and read pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Count register is DEPTH_LOG2+1 bits.
- Reset (async, any time, including mid-burst): pointers = 0, count = 0, infifo_is_empty = 1, s_axis_tready = 0, fill_level = 0, infifo_dout = 0, infifo_last = 0. Memory contents are not reset.
- s_axis_tready is registered. Next value = (count_next != DEPTH). It is 0 during reset and goes to 1 on the first rising edge after reset deasserts.
- Write fires when s_axis_tvalid & s_axis_tready. The word goes to mem[wr_ptr], then wr_ptr++.
- Read fires when infifo_read & ~infifo_is_empty. Then rd_ptr++. infifo_read while empty is ignored, with no pointer or count change.
- FWFT output:
  - infifo_dout / infifo_last = mem[rd_ptr] combinationally when count != 0; forced to 0 when empty.
  - A word written at edge N is visible, with infifo_is_empty = 0, after edge N (1-cycle write-to-read latency).
- infifo_is_empty = (count == 0), derived from the registered count.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - unchanged on simultaneous write and read.
- Full (count == DEPTH): tready is 0, so no write. A read in that cycle makes count DEPTH-1 and tready 1 at the next edge. No same-cycle pass-through when full.
- Empty with simultaneous tvalid and infifo_read: the write is accepted, the read is ignored, count becomes 1.
- flush has priority over write and read in the same cycle. Pointers and count go to 0 and tready goes to 1 at the next edge. The in-flight stream word in the flush cycle is discarded.
- fill_level = count.
- No internal state machine beyond the pointer/count datapath. Under no stimulus may the block produce overflow or underflow of count.

Optional Feature:
- Macro INFIFO_STATS_EN.
- When defined, three extra ports are added:
  - word_count out 32: total accepted stream words, wraps at 2**32.
  - underflow_sticky out 1: set when infifo_read is asserted while empty.
  - batch_count out 16: number of reads whose infifo_last = 1.
- All three reset to 0 and are cleared by flush.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, then idle → infifo_is_empty = 1, infifo_dout = 0, s_axis_tready = 0 in the reset cycle and 1 one edge later, fill_level = 0.
- Write 0xCAFECAFECAFECAFE, then 0x3501350135013501 (tlast = 1 on the second), with no reads → after 2 edges fill_level = 2 and infifo_dout = 0xCAFECAFECAFECAFE; one read → dout = 0x3501350135013501, infifo_last = 1.
- Stream 16 words (i = 0..15) with no reads → s_axis_tready = 0 and fill_level = 16; a 17th tvalid is not accepted; one read → tready = 1 next edge; drain all words in order 0..15 with no loss.
- Continuous write and read with the buffer holding 3 words for 40 cycles → fill_level stays 3; pointer wrap past entry 15 preserves order.
- Read while empty, and simultaneous write with read on empty → no change on the read-while-empty; count = 1 with the written word at dout; with INFIFO_STATS_EN, underflow_sticky = 1.
- flush asserted with 5 words stored plus a valid input word → next edge fill_level = 0, infifo_is_empty = 1, tready = 1; asynchronous reset pulse mid-stream → all outputs at their reset values immediately.
